givens_apply: RTL and testbench
===============================

// Module: givens_apply
// PURPOSE
// - Consumer of the Givens coefficient generator: takes one (cos, sin) pair and rotates a stream of row pairs (x_k, y_k).
// - Computes x' = c*x - s*y and y' = s*x + c*y, with s as delivered (already sign-adjusted). For column 0 this gives x' = r, y' ~ 0.
// - Sits between the coefficient generator and the R/Q row buffers of the QR decomposition; IEEE-754 single throughout.
// PARAMETERS
// - I_EXP    8   exponent width
// - I_MNT    23  mantissa width
// - I_DATA   32  word width (I_EXP+I_MNT+1)
// - N_COLS   8   max elements per rotation; sizes the element counter
// - MUL_LAT  2   fp_mul latency, enable to out_valid
// - ADD_LAT  3   fp_add latency, enable to out_valid
// PORTS
// - clk         in   1       clock, rising edge
// - reset_n     in   1       asynchronous active-low reset
// - coef_valid  in   1       cos/sin valid
// - coef_ready  out  1       coefficient slot free
// - cos         in   I_DATA  cosine, float
// - sin         in   I_DATA  sine, float, sign as produced upstream
// - in_valid    in   1       x_in/y_in valid
// - in_ready    out  1       element accepted when in_valid & in_ready
// - x_in        in   I_DATA  pivot-row element
// - y_in        in   I_DATA  target-row element
// - in_last     in   1       final element of this rotation
// - out_valid   out  1       result valid, one-cycle pulse per element, no backpressure
// - x_out       out  I_DATA  rotated pivot element
// - y_out       out  I_DATA  rotated target element
// - out_last    out  1       marks result of the in_last element
// - err_overrun out  1       sticky; N_COLS elements seen without in_last
// BEHAVIOUR
// - Reset (async, reset_n low): FSM=IDLE; cur/next coef regs and counter cleared.
//   All outputs 0, except coef_ready, which is 1. In-flight pipeline contents are discarded.
// - Coefficient buffer: cur (active) plus next (shadow). coef_ready = !next_full.
//   - A coef handshake fills cur if the FSM is IDLE; otherwise it fills next.
// - FSM IDLE: in_ready=0. On coef handshake -> ROT. col_cnt=0.
// - FSM ROT: in_ready=1. Each handshake increments col_cnt.
//   - Beat with in_last=1, or with col_cnt==N_COLS-1: rotation ends. The forced end sets err_overrun and the beat is tagged last.
//   - At end: if next_full (or coef handshake same cycle), next->cur, stay ROT, zero bubble. Else -> IDLE.
//   - Coefficients used for a beat are those in cur at its accept edge; a swap on the last beat affects the following beat only.
// - Datapath: operands registered on accept.
//   - Four fp_mul compute c*x, s*y, s*x, c*y; results are registered.
//   - s*y sign bit is inverted before the x-lane fp_add. Adder outputs are registered into x_out/y_out.
// - Latency: L = MUL_LAT + ADD_LAT + 3 cycles from accept edge to out_valid. Fixed; throughput 1 element/cycle.
// - out_last travels in an L-deep shift register alongside valid; x_out/y_out hold their last value when out_valid=0.
// - fp enables are driven by the stage valid bits, never tied high, so idle cycles produce no out_valid.
// - NaN/Inf/denormal: passed through the fp units unmodified; no exception flags.
// - Mid-rotation reset: everything is lost; upstream must resend coefficients and the row.
// - err_overrun is cleared only by reset.
// STRUCTURE
// - Shared package (givens_pkg): I_EXP/I_MNT/I_DATA defaults, FP_ONE=32'h3F800000, FP_ZERO, SIGN_BIT mask, rot_state_t {IDLE,ROT}.
//   The coefficient generator uses the same package.
// - Sub-module givens_lane: two fp_mul + one fp_add with an optional sign flip on the second product, computing p*u +/- q*v.
//   Instantiated twice: x-lane (c,x,s,y,minus) and y-lane (s,x,c,y,plus).
// - Top: FSM, coef buffer, counter, valid/last shift register.
// TESTING
// - Identity: cos=3F800000, sin=0, row (x,y)=(2.0,-5.0)x4 -> 4 outputs exactly (2.0,-5.0); last on 4th; first out_valid L cycles after first accept.
// - Zeroing: cos=0.6, sin=-0.8, (x,y)=(3.0,4.0) -> x_out=5.0 within 2 ulp, |y_out|<1e-6, out_last=1.
// - Back-to-back: second coef pair presented during a 3-element row -> coef_ready drops until swap; the 2nd row starts the cycle after in_last with no bubble; outputs contiguous.
// - Gaps: in_valid toggled 1,0,1,0 over 4 elements -> out_valid pattern is identical, delayed by L; no extra pulses.
// - Overrun: N_COLS=8 and 10 beats with no in_last -> 8th beat tagged out_last, err_overrun=1; FSM IDLE, in_ready=0 for beats 9-10.
// - Reset mid-row: reset_n low 1 cycle after 2 beats -> all outputs 0, coef_ready=1, no out_valid afterwards until a new coef+row.

Source files
------------

// File: rtl/givens_pkg.sv
// Shared definitions for the Givens rotation blocks: FP constants, FSM state
// type and the single-precision multiply/add helpers used by the lanes.
package givens_pkg;
    localparam int I_EXP  = 8;
    localparam int I_MNT  = 23;
    localparam int I_DATA = I_EXP + I_MNT + 1;

    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam logic [31:0] SIGN_BIT = 32'h8000_0000;

    typedef enum logic [0:0] {IDLE = 1'b0, ROT = 1'b1} rot_state_t;

    // Round-half-up multiply; zero exponent operands are treated as zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic [47:0]       prod;
        logic [24:0]       m;
        logic signed [9:0] e;
        logic [31:0]       r;
        sgn  = a[31] ^ b[31];
        prod = {24'h00_0000, 1'b1, a[22:0]} * {24'h00_0000, 1'b1, b[22:0]};
        e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            m = {1'b0, prod[47:24]} + {24'h00_0000, prod[23]};
            e = e + 10'sd1;
        end else begin
            m = {1'b0, prod[46:23]} + {24'h00_0000, prod[22]};
        end
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r = {sgn, 8'hFF, a[22:0] | b[22:0]};
        end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00 || e <= 10'sd0) begin
            r = {sgn, 31'h0};
        end else if (e >= 10'sd255) begin
            r = {sgn, 8'hFF, 23'h0};
        end else begin
            r = {sgn, e[7:0], m[22:0]};
        end
        return r;
    endfunction

    // Magnitude-ordered add with three guard bits; exact cancellation gives +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [7:0]        d;
        logic [26:0]       mb;
        logic [26:0]       ms;
        logic [27:0]       s;
        logic [24:0]       m;
        logic signed [9:0] e;
        logic [31:0]       r;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'b000};
        ms = (d > 8'd26) ? 27'h0 : ({1'b1, sml[22:0], 3'b000} >> d);
        e  = $signed({2'b00, big[30:23]});
        s  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        if (s[27]) begin
            s = s >> 1;
            e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && s != 28'h0) begin
                s = s << 1;
                e = e - 10'sd1;
            end
        end
        m = {1'b0, s[26:3]} + {24'h00_0000, s[2]};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (big[30:23] == 8'hFF || sml[30:23] == 8'h00) begin
            r = big;
        end else if (s == 28'h0 || e <= 10'sd0) begin
            r = FP_ZERO;
        end else if (e >= 10'sd255) begin
            r = {big[31], 8'hFF, 23'h0};
        end else begin
            r = {big[31], e[7:0], m[22:0]};
        end
        return r;
    endfunction
endpackage

// File: rtl/givens_lane.sv
// One rotation lane: res = p*u +/- q*v, pipelined; every stage loads only on
// its enable bit, so data holds while no element is in flight.
module givens_lane #(
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 3,
    parameter int STAGES  = MUL_LAT + ADD_LAT + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [STAGES-1:0] en,
    input  logic [31:0]       p,
    input  logic [31:0]       u,
    input  logic [31:0]       q,
    input  logic [31:0]       v,
    input  logic              sub,
    output logic [31:0]       res
);
    import givens_pkg::*;

    localparam int P_STG = MUL_LAT + 1;
    localparam int A_STG = MUL_LAT + 2;

    logic [31:0] p_r;
    logic [31:0] u_r;
    logic [31:0] q_r;
    logic [31:0] v_r;
    logic [31:0] pu_r [MUL_LAT];
    logic [31:0] qv_r [MUL_LAT];
    logic [31:0] pu_hold_r;
    logic [31:0] qv_hold_r;
    logic [31:0] sum_r [ADD_LAT];
    logic [31:0] res_r;

    // Operand, multiplier, product, adder and output stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_r       <= FP_ZERO;
            u_r       <= FP_ZERO;
            q_r       <= FP_ZERO;
            v_r       <= FP_ZERO;
            pu_hold_r <= FP_ZERO;
            qv_hold_r <= FP_ZERO;
            res_r     <= FP_ZERO;
            for (int j = 0; j < MUL_LAT; j++) begin
                pu_r[j] <= FP_ZERO;
                qv_r[j] <= FP_ZERO;
            end
            for (int j = 0; j < ADD_LAT; j++) begin
                sum_r[j] <= FP_ZERO;
            end
        end else begin
            if (en[0]) begin
                p_r <= p;
                u_r <= u;
                q_r <= q;
                v_r <= v;
            end
            if (en[1]) begin
                pu_r[0] <= fp_mul(p_r, u_r);
                qv_r[0] <= fp_mul(q_r, v_r);
            end
            for (int j = 1; j < MUL_LAT; j++) begin
                if (en[j+1]) begin
                    pu_r[j] <= pu_r[j-1];
                    qv_r[j] <= qv_r[j-1];
                end
            end
            if (en[P_STG]) begin
                pu_hold_r <= pu_r[MUL_LAT-1];
                qv_hold_r <= sub ? (qv_r[MUL_LAT-1] ^ SIGN_BIT) : qv_r[MUL_LAT-1];
            end
            if (en[A_STG]) begin
                sum_r[0] <= fp_add(pu_hold_r, qv_hold_r);
            end
            for (int j = 1; j < ADD_LAT; j++) begin
                if (en[A_STG+j]) begin
                    sum_r[j] <= sum_r[j-1];
                end
            end
            if (en[STAGES-1]) begin
                res_r <= sum_r[ADD_LAT-1];
            end
        end
    end

    assign res = res_r;
endmodule

// File: rtl/givens_apply.sv
// Applies a buffered (cos, sin) pair to a stream of row pairs; the shadow
// coefficient slot lets the next rotation start with no bubble.
module givens_apply #(
    parameter int I_EXP   = 8,
    parameter int I_MNT   = 23,
    parameter int I_DATA  = 32,
    parameter int N_COLS  = 8,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    input  logic [I_EXP+I_MNT:0] cos,
    input  logic [I_EXP+I_MNT:0] sin,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [I_EXP+I_MNT:0] x_in,
    input  logic [I_EXP+I_MNT:0] y_in,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [I_DATA-1:0]    x_out,
    output logic [I_DATA-1:0]    y_out,
    output logic                 out_last,
    output logic                 err_overrun
);
    import givens_pkg::*;

    localparam int L  = MUL_LAT + ADD_LAT + 3;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N_COLS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    rot_state_t  state_r;
    rot_state_t  state_nxt_s;
    logic [31:0] cur_c_r;
    logic [31:0] cur_s_r;
    logic [31:0] nxt_c_r;
    logic [31:0] nxt_s_r;
    logic        next_full_r;
    logic [CW-1:0] col_cnt_r;
    logic [L-1:0] vld_r;
    logic [L-1:0] last_r;
    logic        err_r;
    logic        in_ready_s;
    logic        coef_hs_s;
    logic        accept_s;
    logic        cnt_max_s;
    logic        end_s;
    logic        swap_s;

    assign coef_hs_s = coef_valid & ~next_full_r;
    assign accept_s  = in_valid & in_ready_s;
    assign cnt_max_s = (col_cnt_r == CNT_MAX);
    assign end_s     = accept_s & (in_last | cnt_max_s);
    assign swap_s    = end_s & (next_full_r | coef_hs_s);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a rotation end with a pending pair continues in ROT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (coef_hs_s) state_nxt_s = ROT; else state_nxt_s = IDLE;
            ROT:     if (end_s && !swap_s) state_nxt_s = IDLE; else state_nxt_s = ROT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b0;
            ROT:     in_ready_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Active/shadow coefficient buffer; cur changes on the same edge that
    // captures the last beat's operands, so the swap only affects later beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_c_r     <= FP_ZERO;
            cur_s_r     <= FP_ZERO;
            nxt_c_r     <= FP_ZERO;
            nxt_s_r     <= FP_ZERO;
            next_full_r <= 1'b0;
        end else if (state_r == IDLE) begin
            if (coef_hs_s) begin
                cur_c_r <= cos;
                cur_s_r <= sin;
            end
        end else if (end_s) begin
            if (next_full_r) begin
                cur_c_r     <= nxt_c_r;
                cur_s_r     <= nxt_s_r;
                next_full_r <= 1'b0;
            end else if (coef_hs_s) begin
                cur_c_r <= cos;
                cur_s_r <= sin;
            end
        end else if (coef_hs_s) begin
            nxt_c_r     <= cos;
            nxt_s_r     <= sin;
            next_full_r <= 1'b1;
        end
    end

    // Element counter and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt_r <= CNT_ZERO;
            err_r     <= 1'b0;
        end else begin
            if (state_r == IDLE && coef_hs_s) begin
                col_cnt_r <= CNT_ZERO;
            end else if (accept_s) begin
                col_cnt_r <= end_s ? CNT_ZERO : (col_cnt_r + CNT_ONE);
            end
            if (accept_s && cnt_max_s && !in_last) begin
                err_r <= 1'b1;
            end
        end
    end

    // Valid/last tags travel alongside the lane stages and double as enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r  <= {L{1'b0}};
            last_r <= {L{1'b0}};
        end else begin
            vld_r  <= {vld_r[L-2:0], accept_s};
            last_r <= {last_r[L-2:0], end_s};
        end
    end

    givens_lane #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_x_lane (
        .clk(clk), .reset_n(reset_n), .en({vld_r[L-2:0], accept_s}),
        .p(cur_c_r), .u(x_in), .q(cur_s_r), .v(y_in), .sub(1'b1), .res(x_out)
    );

    givens_lane #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_y_lane (
        .clk(clk), .reset_n(reset_n), .en({vld_r[L-2:0], accept_s}),
        .p(cur_s_r), .u(x_in), .q(cur_c_r), .v(y_in), .sub(1'b0), .res(y_out)
    );

    assign in_ready    = in_ready_s;
    assign coef_ready  = ~next_full_r;
    assign out_valid   = vld_r[L-1];
    assign out_last    = last_r[L-1];
    assign err_overrun = err_r;
endmodule

// File: tb/tb_givens_apply.sv
// Directed bench for givens_apply: one task per scenario, expected values
// written out by hand as IEEE-754 single bit patterns.
module tb_givens_apply;
    localparam int L = 8;
    localparam logic [31:0] F_ZERO = 32'h0000_0000;
    localparam logic [31:0] F_ONE  = 32'h3F80_0000;
    localparam logic [31:0] F_M1   = 32'hBF80_0000;
    localparam logic [31:0] F_TWO  = 32'h4000_0000;
    localparam logic [31:0] F_THR  = 32'h4040_0000;
    localparam logic [31:0] F_FOUR = 32'h4080_0000;
    localparam logic [31:0] F_FIVE = 32'h40A0_0000;
    localparam logic [31:0] F_M5   = 32'hC0A0_0000;
    localparam logic [31:0] F_0P6  = 32'h3F19_999A;
    localparam logic [31:0] F_M0P8 = 32'hBF4C_CCCD;

    logic        clk;
    logic        reset_n;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] cos;
    logic [31:0] sin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        in_last;
    logic        out_valid;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic        out_last;
    logic        err_overrun;

    int n_vec;
    int n_bad;
    int cyc;
    int          oc_q[$];
    logic [31:0] ox_q[$];
    logic [31:0] oy_q[$];
    logic        ol_q[$];

    givens_apply dut (
        .clk(clk), .reset_n(reset_n),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .cos(cos), .sin(sin),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .in_last(in_last),
        .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .out_last(out_last),
        .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            oc_q.push_back(cyc);
            ox_q.push_back(x_out);
            oy_q.push_back(y_out);
            ol_q.push_back(out_last);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_q();
        oc_q.delete();
        ox_q.delete();
        oy_q.delete();
        ol_q.delete();
    endtask

    task automatic send_coef(input logic [31:0] c, input logic [31:0] s);
        int k;
        k = 0;
        coef_valid = 1'b1;
        cos = c;
        sin = s;
        while (!coef_ready && k < 20) begin
            step();
            k++;
        end
        if (!coef_ready) begin
            n_vec++; n_bad++;
            $display("FAIL coef_wait got coef_ready=0 want 1 within 20 cycles");
        end
        step();
        coef_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] x, input logic [31:0] y, input logic last,
                             output int acc);
        int k;
        k = 0;
        in_valid = 1'b1;
        x_in = x;
        y_in = y;
        in_last = last;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL beat_wait got in_ready=0 want 1 within 20 cycles");
        end
        acc = cyc;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        coef_valid = 1'b0; cos = F_ZERO; sin = F_ZERO;
        in_valid = 1'b0; x_in = F_ZERO; y_in = F_ZERO; in_last = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        n_vec++;
        if ({coef_ready, in_ready, out_valid, out_last, err_overrun, x_out, y_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_ZERO, F_ZERO}) begin
            n_bad++;
            $display("FAIL reset_state got cr=%b ir=%b ov=%b ol=%b err=%b x=%h y=%h want cr=1 rest 0",
                     coef_ready, in_ready, out_valid, out_last, err_overrun, x_out, y_out);
        end
    endtask

    task automatic test_identity();
        int acc0;
        int a;
        clear_q();
        send_coef(F_ONE, F_ZERO);
        for (int i = 0; i < 4; i++) begin
            send_beat(F_TWO, F_M5, (i == 3), a);
            if (i == 0) acc0 = a;
        end
        idle(L + 4);
        n_vec++;
        if (oc_q.size() != 4) begin
            n_bad++;
            $display("FAIL ident_count got %0d want 4", oc_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (oc_q[i] !== acc0 + L + i) begin
                n_bad++;
                $display("FAIL ident_cycle[%0d] got %0d want %0d", i, oc_q[i], acc0 + L + i);
            end
            n_vec++;
            if ({ox_q[i], oy_q[i], ol_q[i]} !== {F_TWO, F_M5, (i == 3)}) begin
                n_bad++;
                $display("FAIL ident_data[%0d] got x=%h y=%h last=%b want x=%h y=%h last=%b",
                         i, ox_q[i], oy_q[i], ol_q[i], F_TWO, F_M5, (i == 3));
            end
        end
    endtask

    task automatic test_zeroing();
        int a;
        int diff;
        clear_q();
        send_coef(F_0P6, F_M0P8);
        send_beat(F_THR, F_FOUR, 1'b1, a);
        idle(L + 4);
        n_vec++;
        if (oc_q.size() != 1) begin
            n_bad++;
            $display("FAIL zero_count got %0d want 1", oc_q.size());
        end
        diff = int'(ox_q[0]) - int'(F_FIVE);
        n_vec++;
        if (ox_q[0][31] !== 1'b0 || diff > 2 || diff < -2) begin
            n_bad++;
            $display("FAIL zero_x got %h want %h within 2 ulp", ox_q[0], F_FIVE);
        end
        // |y| < 2^-20 guarantees |y| < 1e-6
        n_vec++;
        if (oy_q[0][30:23] > 8'd106) begin
            n_bad++;
            $display("FAIL zero_y got %h want magnitude below 1e-6", oy_q[0]);
        end
        n_vec++;
        if (ol_q[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_last got %b want 1", ol_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int a;
        logic [31:0] ex [6];
        logic [31:0] ey [6];
        ex = '{F_TWO, F_TWO, F_TWO, F_M1, F_M1, F_M1};
        ey = '{F_M5, F_M5, F_M5, F_THR, F_THR, F_THR};
        clear_q();
        send_coef(F_ONE, F_ZERO);
        send_beat(F_TWO, F_M5, 1'b0, a0);
        // second pair offered together with the middle beat
        in_valid = 1'b1; x_in = F_TWO; y_in = F_M5; in_last = 1'b0;
        coef_valid = 1'b1; cos = F_ZERO; sin = F_ONE;
        step();
        coef_valid = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if ({coef_ready, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_pending got cr=%b ir=%b want cr=0 ir=1", coef_ready, in_ready);
        end
        send_beat(F_TWO, F_M5, 1'b1, a);
        n_vec++;
        if ({coef_ready, in_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_swap got cr=%b ir=%b want cr=1 ir=1", coef_ready, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            send_beat(F_THR, F_ONE, (i == 2), a);
            n_vec++;
            if (a !== a0 + 3 + i) begin
                n_bad++;
                $display("FAIL b2b_accept[%0d] got cycle %0d want %0d", i, a, a0 + 3 + i);
            end
        end
        idle(L + 4);
        n_vec++;
        if (in_ready !== 1'b0 || oc_q.size() != 6) begin
            n_bad++;
            $display("FAIL b2b_end got ir=%b outs=%0d want ir=0 outs=6", in_ready, oc_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({oc_q[i], ox_q[i], oy_q[i], ol_q[i]} !==
                {a0 + L + i, ex[i], ey[i], (i == 2 || i == 5)}) begin
                n_bad++;
                $display("FAIL b2b_out[%0d] got cyc=%0d x=%h y=%h last=%b want cyc=%0d x=%h y=%h last=%b",
                         i, oc_q[i], ox_q[i], oy_q[i], ol_q[i], a0 + L + i, ex[i], ey[i],
                         (i == 2 || i == 5));
            end
        end
    endtask

    task automatic test_gaps();
        int t0;
        logic [31:0] ex [4];
        ex = '{F_ONE, F_TWO, F_THR, F_FOUR};
        clear_q();
        send_coef(F_ONE, F_ZERO);
        t0 = cyc;
        for (int t = 0; t < 7; t++) begin
            in_valid = (t % 2 == 0);
            x_in = ex[t / 2];
            y_in = F_M5;
            in_last = (t == 6);
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        idle(L + 6);
        n_vec++;
        if (oc_q.size() != 4) begin
            n_bad++;
            $display("FAIL gaps_count got %0d want 4", oc_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({oc_q[i], ox_q[i], oy_q[i], ol_q[i]} !== {t0 + L + 2 * i, ex[i], F_M5, (i == 3)}) begin
                n_bad++;
                $display("FAIL gaps_out[%0d] got cyc=%0d x=%h y=%h last=%b want cyc=%0d x=%h y=%h last=%b",
                         i, oc_q[i], ox_q[i], oy_q[i], ol_q[i], t0 + L + 2 * i, ex[i], F_M5, (i == 3));
            end
        end
    endtask

    task automatic test_overrun();
        int t0;
        clear_q();
        send_coef(F_ONE, F_ZERO);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; x_in = F_TWO; y_in = F_M5; in_last = 1'b0;
            n_vec++;
            if (in_ready !== (k < 8)) begin
                n_bad++;
                $display("FAIL ovr_ready[%0d] got %b want %b", k, in_ready, (k < 8));
            end
            step();
        end
        in_valid = 1'b0;
        idle(L + 4);
        n_vec++;
        if (err_overrun !== 1'b1 || oc_q.size() != 8) begin
            n_bad++;
            $display("FAIL ovr_flag got err=%b outs=%0d want err=1 outs=8", err_overrun, oc_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({oc_q[i], ol_q[i]} !== {t0 + L + i, (i == 7)}) begin
                n_bad++;
                $display("FAIL ovr_out[%0d] got cyc=%0d last=%b want cyc=%0d last=%b",
                         i, oc_q[i], ol_q[i], t0 + L + i, (i == 7));
            end
        end
    endtask

    task automatic test_reset_mid_row();
        int a;
        clear_q();
        send_coef(F_ONE, F_ZERO);
        send_beat(F_THR, F_ONE, 1'b0, a);
        send_beat(F_THR, F_ONE, 1'b0, a);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({coef_ready, in_ready, out_valid, out_last, err_overrun, x_out, y_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F_ZERO, F_ZERO}) begin
            n_bad++;
            $display("FAIL midrst_state got cr=%b ir=%b ov=%b ol=%b err=%b x=%h y=%h want cr=1 rest 0",
                     coef_ready, in_ready, out_valid, out_last, err_overrun, x_out, y_out);
        end
        step();
        reset_n = 1'b1;
        idle(L + 8);
        n_vec++;
        if (oc_q.size() != 0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_quiet got outs=%0d ir=%b want outs=0 ir=0", oc_q.size(), in_ready);
        end
        send_coef(F_ZERO, F_ONE);
        send_beat(F_THR, F_ONE, 1'b1, a);
        idle(L + 2);
        n_vec++;
        if (oc_q.size() != 1 || {ox_q[0], oy_q[0], ol_q[0]} !== {F_M1, F_THR, 1'b1}) begin
            n_bad++;
            $display("FAIL midrst_resume got outs=%0d x=%h y=%h want outs=1 x=%h y=%h",
                     oc_q.size(), ox_q[0], oy_q[0], F_M1, F_THR);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc = 0;
        test_reset();
        test_identity();
        test_zeroing();
        test_back_to_back();
        test_gaps();
        test_overrun();
        test_reset_mid_row();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
